// File: rtl/fpu_div_pkg.sv
// Shared FPU types and constants: the 35-bit extended unrounded result format
// and the divider state encoding.
package fpu_pkg;
  typedef logic [34:0] fp_ext_t;

  localparam int         FP_BIAS    = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'hff;
  localparam fp_ext_t    QNAN_EXT   = {1'b0, 9'h1ff, 22'h1, 3'h0};
  localparam int         DIV_QBITS  = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic fp_ext_t fp_ext_inf(input logic sign);
    return {sign, FP_EXP_MAX, 26'h0};
  endfunction

  function automatic fp_ext_t fp_ext_zero(input logic sign);
    return {sign, 34'h0};
  endfunction
endpackage

// File: rtl/fpu_div_if.sv
// Issue/result bundle between the EX stage and the divider.
interface fpu_div_if;
  import fpu_pkg::*;

  logic [31:0] opa;
  logic [31:0] opb;
  logic        new_input;
  fp_ext_t     out;
  logic        out_valid;
  logic        fpu_div_busy;

  modport master (output opa, opb, new_input, input out, out_valid, fpu_div_busy);
  modport slave  (input opa, opb, new_input, output out, out_valid, fpu_div_busy);
endinterface

// File: rtl/fpu_div_classify.sv
// Per-operand class flags for binary32; denormals count as zero (flushed).
module fpu_classify (
  input  logic [30:0] op,
  output logic        zero,
  output logic        inf,
  output logic        nan
);
  assign zero = (op[30:23] == 8'h00);
  assign inf  = (op[30:23] == 8'hff) && (op[22:0] == 23'h0);
  assign nan  = (op[30:23] == 8'hff) && (op[22:0] != 23'h0);
endmodule

// File: rtl/fpu_div.sv
// Restoring radix-2 binary32 divider, one quotient bit per cycle.
// state | meaning
// IDLE  | no operation since reset
// DIV   | iterating, cnt selects quotient bit 26-cnt
// DONE  | out holds the result of the latest new_input
module fpu_div
  import fpu_pkg::*;
(
  input logic       clk,
  input logic       rst,
  fpu_div_if.slave  bus
);
  logic zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;

  fpu_classify u_cls_a (.op(bus.opa[30:0]), .zero(zero_a), .inf(inf_a), .nan(nan_a));
  fpu_classify u_cls_b (.op(bus.opb[30:0]), .zero(zero_b), .inf(inf_b), .nan(nan_b));

  div_state_t   state, state_nxt;
  logic [4:0]   cnt;
  logic [24:0]  rem;
  logic [25:0]  q;
  logic [23:0]  mb;
  logic [7:0]   ea, eb;
  logic         sign;
  fp_ext_t      out_q;

  logic         sign_in;
  logic         special;
  fp_ext_t      special_res;

  assign sign_in = bus.opa[31] ^ bus.opb[31];

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (nan_a)                                      special_res = {bus.opa, 3'h0};
    else if (nan_b)                                 special_res = {bus.opb, 3'h0};
    else if ((inf_a && inf_b) || (zero_a && zero_b)) special_res = QNAN_EXT;
    else if (inf_a || zero_b)                       special_res = fp_ext_inf(sign_in);
    else if (zero_a || inf_b)                       special_res = fp_ext_zero(sign_in);
    else                                            special     = 1'b0;
  end

  // One restoring step; on the final step q_full/rem_nxt are the complete result.
  logic         ge;
  logic [24:0]  rem_nxt;
  logic [26:0]  q_full;
  logic         last;

  assign ge      = (rem >= {1'b0, mb});
  assign rem_nxt = (ge ? (rem - {1'b0, mb}) : rem) << 1;
  assign q_full  = {q, ge};
  assign last    = (state == DIV) && (cnt == 5'(DIV_QBITS - 1));

  logic signed [9:0] e;
  logic [9:0]        bias;
  logic [24:0]       mant;
  logic              sticky;
  fp_ext_t           div_res;

  always_comb begin
    if (q_full[26]) begin
      mant   = q_full[25:1];
      sticky = q_full[0] | (rem_nxt != '0);
      bias   = 10'(FP_BIAS);
    end else begin
      mant   = q_full[24:0];
      sticky = (rem_nxt != '0);
      bias   = 10'(FP_BIAS - 1);
    end
    e = 10'({2'b00, ea}) - 10'({2'b00, eb}) + bias;
    if (e >= 10'sd255)    div_res = fp_ext_inf(sign);
    else if (e <= 10'sd0) div_res = fp_ext_zero(sign);
    else                  div_res = {sign, e[7:0], mant, sticky};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (last) state_nxt = DONE;
    if (bus.new_input) state_nxt = special ? DONE : DIV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      cnt   <= '0;
      rem   <= '0;
      q     <= '0;
      mb    <= '0;
      ea    <= '0;
      eb    <= '0;
      sign  <= 1'b0;
    end else if (bus.new_input) begin
      cnt  <= '0;
      rem  <= {2'b01, bus.opa[22:0]};
      q    <= '0;
      mb   <= {1'b1, bus.opb[22:0]};
      ea   <= bus.opa[30:23];
      eb   <= bus.opb[30:23];
      sign <= sign_in;
      if (special) out_q <= special_res;
    end else if (state == DIV) begin
      cnt <= cnt + 5'd1;
      rem <= rem_nxt;
      q   <= q_full[25:0];
      if (last) out_q <= div_res;
    end
  end

  assign bus.out          = out_q;
  assign bus.out_valid    = (state == DONE);
  assign bus.fpu_div_busy = bus.new_input | (state == DIV);
endmodule
